// File: rtl/fetch_align_buffer.sv
// Byte-window fetch aligner: merges prefetch FIFO entries into a contiguous stream for decode.
// Optional zero-latency head bypass when the window is empty: define FETCH_ALIGN_BYPASS_EN.
module fetch_align_buffer #(
  parameter int unsigned LINE_BYTES   = 8,
  parameter int unsigned WINDOW_BYTES = 16,
  parameter int unsigned CNT_W        = 6,
  parameter logic [3:0]  GP_CODE      = 4'hF,
  parameter logic [3:0]  PF_CODE      = 4'hE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pr_reset,
  input  logic [31:0]                  wr_eip,
  output logic [31:0]                  prefetch_eip,
  output logic                         prefetchfifo_accept_do,
  input  logic [4+8*LINE_BYTES-1:0]    prefetchfifo_accept_data,
  input  logic                         prefetchfifo_accept_empty,
  output logic [CNT_W-1:0]             fetch_valid,
  output logic [8*WINDOW_BYTES-1:0]    fetch,
  output logic                         fetch_limit,
  output logic                         fetch_page_fault,
  input  logic [CNT_W-1:0]             dec_consume
);

  localparam int unsigned DATA_W = 8 * LINE_BYTES;
  localparam int unsigned WIN_W  = 8 * WINDOW_BYTES;
  localparam int unsigned CMP_W  = CNT_W + 1;

  logic [WIN_W-1:0]  win_q, win_d;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic              gp_q, gp_d, pf_q, pf_d;

  logic [3:0]        head_status;
  logic [DATA_W-1:0] head_raw, head_bytes;
  logic [WIN_W-1:0]  head_ext;
  logic [CNT_W-1:0]  head_cnt;
  logic              head_fault;
  logic [CNT_W-1:0]  cons_nb;
  logic              space_ok, accept_c, byp_c;

  assign prefetch_eip = wr_eip;
  assign head_status  = prefetchfifo_accept_data[DATA_W+3 -: 4];
  assign head_raw     = prefetchfifo_accept_data[DATA_W-1:0];
  assign head_fault   = (head_status == GP_CODE) || (head_status == PF_CODE);

  // Decode head status into a byte count; bytes beyond the count are zeroed.
  always_comb begin
    head_cnt = '0;
    if (head_status != 4'd0 && head_status <= 4'(LINE_BYTES))
      head_cnt = CNT_W'(head_status);
    head_bytes = '0;
    for (int i = 0; i < LINE_BYTES; i++)
      if (CNT_W'(i) < head_cnt) head_bytes[8*i +: 8] = head_raw[8*i +: 8];
  end
  assign head_ext = WIN_W'(head_bytes);

  assign cons_nb  = (dec_consume > occ_q) ? occ_q : dec_consume;
  assign space_ok = (CMP_W'(WINDOW_BYTES) - CMP_W'(occ_q) + CMP_W'(cons_nb)) >= CMP_W'(head_cnt);
  assign accept_c = !rst && !pr_reset && !prefetchfifo_accept_empty && !head_fault && space_ok;
  assign prefetchfifo_accept_do = accept_c;

`ifdef FETCH_ALIGN_BYPASS_EN
  assign byp_c = !rst && !pr_reset && (occ_q == '0) && !prefetchfifo_accept_empty && (head_cnt != '0);
`else
  assign byp_c = 1'b0;
`endif

  // Next window: consume from the visible bytes, then append a popped entry behind them.
  always_comb begin
    logic [WIN_W-1:0] src_win;
    logic [CNT_W-1:0] src_occ, cons, base;
    src_win = byp_c ? head_ext : win_q;
    src_occ = byp_c ? head_cnt : occ_q;
    cons    = (dec_consume > src_occ) ? src_occ : dec_consume;
    base    = src_occ - cons;
    win_d   = src_win >> {cons, 3'b000};
    occ_d   = base;
    if (accept_c && !byp_c) begin
      win_d = win_d | (head_ext << {base, 3'b000});
      occ_d = base + head_cnt;
    end
    if (pr_reset) begin
      win_d = '0;
      occ_d = '0;
    end
    gp_d = gp_q || (!prefetchfifo_accept_empty && head_status == GP_CODE && occ_d == '0);
    pf_d = pf_q || (!prefetchfifo_accept_empty && head_status == PF_CODE && occ_d == '0);
    if (pr_reset) begin
      gp_d = 1'b0;
      pf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q <= '0;
      occ_q <= '0;
      gp_q  <= 1'b0;
      pf_q  <= 1'b0;
    end else begin
      win_q <= win_d;
      occ_q <= occ_d;
      gp_q  <= gp_d;
      pf_q  <= pf_d;
    end
  end

  assign fetch_limit      = gp_q;
  assign fetch_page_fault = pf_q;

  // Present the window with bytes at and above the valid count forced to zero.
  always_comb begin
    logic [WIN_W-1:0] vis_win;
    fetch_valid = byp_c ? head_cnt : occ_q;
    if (gp_q || pf_q) fetch_valid = '0;
    vis_win = byp_c ? head_ext : win_q;
    fetch   = '0;
    for (int i = 0; i < WINDOW_BYTES; i++)
      if (CNT_W'(i) < fetch_valid) fetch[8*i +: 8] = vis_win[8*i +: 8];
  end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Scoreboard bench for fetch_align_buffer: byte stream queue plus occupancy model.
module tb_fetch_align_buffer;
  localparam int unsigned LB = 8;
  localparam int unsigned WB = 16;
  localparam int unsigned CW = 6;
  localparam int unsigned DW = 4 + 8 * LB;

  logic          clk = 1'b0;
  logic          rst, pr_reset;
  logic [31:0]   wr_eip, prefetch_eip;
  logic          acc_do;
  logic [DW-1:0] acc_data;
  logic          acc_empty;
  logic [CW-1:0] fetch_valid, dec_consume;
  logic [8*WB-1:0] fetch;
  logic          fetch_limit, fetch_page_fault;

  logic [DW-1:0] fifo_q[$];
  logic [7:0]    exp_q[$];
  int            model_occ;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  fetch_align_buffer dut (
    .clk(clk), .rst(rst), .pr_reset(pr_reset), .wr_eip(wr_eip), .prefetch_eip(prefetch_eip),
    .prefetchfifo_accept_do(acc_do), .prefetchfifo_accept_data(acc_data),
    .prefetchfifo_accept_empty(acc_empty), .fetch_valid(fetch_valid), .fetch(fetch),
    .fetch_limit(fetch_limit), .fetch_page_fault(fetch_page_fault), .dec_consume(dec_consume)
  );

  function automatic int head_cnt_m();
    logic [DW-1:0] h;
    logic [3:0] st;
    if (fifo_q.size() == 0) return 0;
    h  = fifo_q[0];
    st = h[DW-1 -: 4];
    return (st >= 4'd1 && st <= 4'(LB)) ? int'(st) : 0;
  endfunction

  function automatic int exp_vis();
`ifdef FETCH_ALIGN_BYPASS_EN
    if (!pr_reset && model_occ == 0 && head_cnt_m() != 0) return head_cnt_m();
`endif
    return model_occ;
  endfunction

  function automatic logic [8*WB-1:0] exp_window(input int v);
    logic [8*WB-1:0] w;
    w = '0;
    for (int i = 0; i < v && i < exp_q.size(); i++) w[8*i +: 8] = exp_q[i];
    return w;
  endfunction

  task automatic drive_head();
    if (fifo_q.size() > 0) begin
      acc_data  = fifo_q[0];
      acc_empty = 1'b0;
    end else begin
      acc_data  = '0;
      acc_empty = 1'b1;
    end
  endtask

  task automatic push_entry(input logic [3:0] st, input logic [7:0] base);
    logic [DW-1:0] e;
    e = '0;
    e[DW-1 -: 4] = st;
    for (int j = 0; j < LB; j++) e[8*j +: 8] = base + 8'(j);
    fifo_q.push_back(e);
    if (st >= 4'd1 && st <= 4'(LB))
      for (int j = 0; j < int'(st); j++) exp_q.push_back(base + 8'(j));
    drive_head();
  endtask

  // One clock: predict pop/consume from the model, check the pop, then retire bytes.
  task automatic tick();
    int cnt, d, cons, nxt;
    logic fault, empty_m, exp_acc, byp;
    logic [DW-1:0] h;
    @(negedge clk);
    empty_m = (fifo_q.size() == 0);
    fault = 1'b0;
    if (!empty_m) begin
      h = fifo_q[0];
      fault = (h[DW-1 -: 4] == 4'hF) || (h[DW-1 -: 4] == 4'hE);
    end
    cnt  = head_cnt_m();
    d    = int'(dec_consume);
    cons = (d < model_occ) ? d : model_occ;
    exp_acc = !pr_reset && !empty_m && !fault && (int'(WB) - model_occ + cons >= cnt);
    byp = 1'b0;
`ifdef FETCH_ALIGN_BYPASS_EN
    byp = !pr_reset && model_occ == 0 && !empty_m && cnt != 0;
`endif
    if (byp) begin
      cons = (d < cnt) ? d : cnt;
      nxt  = cnt - cons;
    end else begin
      nxt = model_occ - cons + (exp_acc ? cnt : 0);
    end
    if (pr_reset) begin
      nxt  = 0;
      cons = 0;
    end
    checks++;
    if (acc_do !== exp_acc) begin
      errors++;
      $display("FAIL accept_do occ=%0d dec=%0d got %b want %b", model_occ, d, acc_do, exp_acc);
    end
    @(posedge clk);
    #1;
    model_occ = nxt;
    if (pr_reset) begin
      fifo_q.delete();
      exp_q.delete();
    end else begin
      if (exp_acc) void'(fifo_q.pop_front());
      repeat (cons) if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    drive_head();
  endtask

  task automatic test_reset();
    rst = 1'b1; pr_reset = 1'b0; dec_consume = '0; wr_eip = 32'h0000_FFF0;
    drive_head();
    repeat (2) @(posedge clk);
    #1;
    push_entry(4'd8, 8'hEE);
    #1;
    checks++;
    if (acc_do !== 1'b0) begin errors++; $display("FAIL rst_accept got %b want 0", acc_do); end
    fifo_q.delete(); exp_q.delete(); drive_head();
    model_occ = 0;
    rst = 1'b0;
    #1;
    checks++;
    if (fetch_valid !== '0 || fetch !== '0) begin
      errors++; $display("FAIL reset_window got valid=%0d fetch=%h want 0", fetch_valid, fetch);
    end
    checks++;
    if (acc_do !== 1'b0 || fetch_limit !== 1'b0 || fetch_page_fault !== 1'b0) begin
      errors++; $display("FAIL reset_flags got acc=%b gp=%b pf=%b want 0", acc_do, fetch_limit, fetch_page_fault);
    end
    checks++;
    if (prefetch_eip !== 32'h0000_FFF0) begin
      errors++; $display("FAIL prefetch_eip got %h want 0000fff0", prefetch_eip);
    end
  endtask

  task automatic test_fill_stall();
    push_entry(4'd8, 8'h10); push_entry(4'd5, 8'h20); push_entry(4'd8, 8'h30);
    dec_consume = '0;
    tick();
    checks++;
    if (fetch_valid !== 6'd8 || fetch !== exp_window(8)) begin
      errors++; $display("FAIL fill8 got valid=%0d fetch=%h want 8", fetch_valid, fetch);
    end
    tick();
    checks++;
    if (fetch_valid !== 6'd13 || fetch !== exp_window(13)) begin
      errors++; $display("FAIL fill13 got valid=%0d fetch=%h want 13", fetch_valid, fetch);
    end
    checks++;
    if (acc_do !== 1'b0) begin errors++; $display("FAIL stall got %b want 0", acc_do); end
    tick();
    checks++;
    if (fetch_valid !== 6'd13) begin errors++; $display("FAIL stall_hold got %0d want 13", fetch_valid); end
  endtask

  task automatic test_consume_pop();
    logic [8*WB-1:0] f;
    logic ok;
    dec_consume = 6'd10;
    #1;
    checks++;
    if (acc_do !== 1'b1) begin errors++; $display("FAIL same_cycle_pop got %b want 1", acc_do); end
    tick();
    dec_consume = '0;
    #1;
    f = fetch;
    checks++;
    if (fetch_valid !== 6'd11) begin errors++; $display("FAIL merge_valid got %0d want 11", fetch_valid); end
    checks++;
    if (f[7:0] !== 8'h22) begin errors++; $display("FAIL merge_byte0 got %h want 22", f[7:0]); end
    ok = 1'b1;
    for (int i = 3; i <= 10; i++) if (f[8*i +: 8] !== 8'h30 + 8'(i - 3)) ok = 1'b0;
    checks++;
    if (!ok || f !== exp_window(11)) begin errors++; $display("FAIL merge_window got %h want %h", f, exp_window(11)); end
    dec_consume = 6'd11;
    tick();
    dec_consume = '0;
    #1;
    checks++;
    if (fetch_valid !== '0) begin errors++; $display("FAIL drain got %0d want 0", fetch_valid); end
  endtask

  task automatic test_fault();
    push_entry(4'd3, 8'h40); push_entry(4'hE, 8'h00);
    tick();
    checks++;
    if (fetch_valid !== 6'd3 || fetch_page_fault !== 1'b0 || fetch_limit !== 1'b0) begin
      errors++; $display("FAIL pf_pending got valid=%0d pf=%b gp=%b want 3,0,0", fetch_valid, fetch_page_fault, fetch_limit);
    end
    tick();
    checks++;
    if (fetch_page_fault !== 1'b0) begin errors++; $display("FAIL pf_early got %b want 0", fetch_page_fault); end
    dec_consume = 6'd3;
    tick();
    dec_consume = '0;
    #1;
    checks++;
    if (fetch_page_fault !== 1'b1 || fetch_valid !== '0 || fetch_limit !== 1'b0) begin
      errors++; $display("FAIL pf_raise got pf=%b valid=%0d gp=%b want 1,0,0", fetch_page_fault, fetch_valid, fetch_limit);
    end
    tick();
    checks++;
    if (fetch_page_fault !== 1'b1) begin errors++; $display("FAIL pf_hold got %b want 1", fetch_page_fault); end
    pr_reset = 1'b1;
    tick();
    pr_reset = 1'b0;
    #1;
    checks++;
    if (fetch_page_fault !== 1'b0) begin errors++; $display("FAIL pf_clear got %b want 0", fetch_page_fault); end
    push_entry(4'hF, 8'h00);
    tick();
    checks++;
    if (fetch_limit !== 1'b1 || fetch_page_fault !== 1'b0 || fetch_valid !== '0) begin
      errors++; $display("FAIL gp_raise got gp=%b pf=%b valid=%0d want 1,0,0", fetch_limit, fetch_page_fault, fetch_valid);
    end
    pr_reset = 1'b1;
    tick();
    pr_reset = 1'b0;
    #1;
    checks++;
    if (fetch_limit !== 1'b0) begin errors++; $display("FAIL gp_clear got %b want 0", fetch_limit); end
  endtask

  task automatic test_flush();
    push_entry(4'd8, 8'h50); push_entry(4'd1, 8'h60); push_entry(4'd8, 8'h70);
    tick(); tick();
    checks++;
    if (fetch_valid !== 6'd9) begin errors++; $display("FAIL flush_pre got %0d want 9", fetch_valid); end
    dec_consume = 6'd4;
    pr_reset = 1'b1;
    #1;
    checks++;
    if (acc_do !== 1'b0) begin errors++; $display("FAIL flush_nopop got %b want 0", acc_do); end
    tick();
    pr_reset = 1'b0;
    dec_consume = '0;
    #1;
    checks++;
    if (fetch_valid !== '0 || fetch !== '0) begin
      errors++; $display("FAIL flush_post got valid=%0d fetch=%h want 0", fetch_valid, fetch);
    end
  endtask

  task automatic test_clamp();
    push_entry(4'd6, 8'h80);
    tick();
    checks++;
    if (fetch_valid !== 6'd6) begin errors++; $display("FAIL clamp_pre got %0d want 6", fetch_valid); end
    dec_consume = 6'd20;
    tick();
    dec_consume = '0;
    #1;
    checks++;
    if (fetch_valid !== '0) begin errors++; $display("FAIL clamp_zero got %0d want 0", fetch_valid); end
    push_entry(4'd4, 8'h90);
    tick();
    checks++;
    if (fetch_valid !== 6'd4 || fetch !== exp_window(4)) begin
      errors++; $display("FAIL clamp_refill got valid=%0d fetch=%h want 4", fetch_valid, fetch);
    end
    dec_consume = 6'd4;
    tick();
    dec_consume = '0;
  endtask

  task automatic test_invalid_status();
    push_entry(4'd0, 8'hA0); push_entry(4'd9, 8'hA8); push_entry(4'hC, 8'hB0); push_entry(4'd2, 8'hC0);
    tick(); tick(); tick();
    checks++;
    if (fetch_valid !== '0) begin errors++; $display("FAIL invalid_discard got %0d want 0", fetch_valid); end
    tick();
    checks++;
    if (fetch_valid !== 6'd2 || fetch !== exp_window(2)) begin
      errors++; $display("FAIL invalid_next got valid=%0d fetch=%h want 2", fetch_valid, fetch);
    end
    dec_consume = 6'd2;
    tick();
    dec_consume = '0;
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    for (int c = 0; c < 300; c++) begin
      while (fifo_q.size() < 3) push_entry(4'($urandom_range(0, 8)), 8'($urandom));
      dec_consume = 6'($urandom_range(0, exp_vis() + 3));
      tick();
      #1;
      checks++;
      if (int'(fetch_valid) !== exp_vis() || fetch !== exp_window(exp_vis())) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL stream cyc=%0d got valid=%0d fetch=%h want %0d %h",
                              c, fetch_valid, fetch, exp_vis(), exp_window(exp_vis()));
      end
    end
    pr_reset = 1'b1; dec_consume = '0;
    tick();
    pr_reset = 1'b0;
  endtask

`ifdef FETCH_ALIGN_BYPASS_EN
  task automatic test_bypass();
    push_entry(4'd8, 8'hD0);
    dec_consume = 6'd3;
    #1;
    checks++;
    if (fetch_valid !== 6'd8 || fetch[7:0] !== 8'hD0) begin
      errors++; $display("FAIL bypass_now got valid=%0d b0=%h want 8 d0", fetch_valid, fetch[7:0]);
    end
    tick();
    dec_consume = '0;
    #1;
    checks++;
    if (fetch_valid !== 6'd5 || fetch !== exp_window(5)) begin
      errors++; $display("FAIL bypass_next got valid=%0d fetch=%h want 5", fetch_valid, fetch);
    end
    dec_consume = 6'd5;
    tick();
    dec_consume = '0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill_stall();
    test_consume_pop();
    test_fault();
    test_flush();
    test_clamp();
    test_invalid_status();
`ifdef FETCH_ALIGN_BYPASS_EN
    test_bypass();
`endif
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_align_buffer.md
Name: fetch_align_buffer

Overview:
- Parametrised successor to the current fetch stage. Sits between the prefetch FIFO and decode.
- Holds a WINDOW_BYTES-deep byte window that merges successive prefetch entries, so decode sees a contiguous byte stream that crosses entry boundaries.
- Decode retires any byte count per cycle. Limit and page faults are reported in order, once all bytes ahead of them have been consumed.

Parameters:
- LINE_BYTES, 8: data bytes per prefetch FIFO entry; legal values 4 or 8.
- WINDOW_BYTES, 16: byte window depth; power of two, at least 2*LINE_BYTES, at most 32.
- CNT_W, 6: width of byte-count ports; at least clog2(WINDOW_BYTES+1).
- GP_CODE, 4'hF: entry status code meaning limit (GP) fault.
- PF_CODE, 4'hE: entry status code meaning page fault.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- pr_reset  in  1  pipeline flush.
- wr_eip  in  32  committed EIP.
- prefetch_eip  out  32  equal to wr_eip, combinational.
- prefetchfifo_accept_do  out  1  pops the FIFO head.
- prefetchfifo_accept_data  in  4+8*LINE_BYTES  status[MSB-:4] followed by data; byte 0 is in the LSBs.
- prefetchfifo_accept_empty  in  1  FIFO empty.
- fetch_valid  out  CNT_W  valid bytes presented to decode.
- fetch  out  8*WINDOW_BYTES  byte window; byte 0 is the oldest byte, bytes at index fetch_valid and above are zero.
- fetch_limit  out  1  GP fault reached.
- fetch_page_fault  out  1  page fault reached.
- dec_consume  in  CNT_W  bytes retired by decode this cycle.

Behaviour:
- Entry status codes:
  - 1..LINE_BYTES: valid byte count for the entry.
  - GP_CODE / PF_CODE: fault entry.
  - Any other value is treated as 0 valid bytes; the entry is popped and discarded.
- State:
  - Byte array buf[WINDOW_BYTES].
  - Occupancy register occ, range 0..WINDOW_BYTES.
- Reset: rst forces occ=0 and clears buf. Resulting output values:
  - fetch_valid=0, fetch=0.
  - fetch_limit=0, fetch_page_fault=0.
  - prefetchfifo_accept_do=0.
- Consume:
  - cons = min(dec_consume, occ); an oversize request is clamped.
  - The window shifts down by cons bytes.
- Pop (combinational): prefetchfifo_accept_do = !rst && !pr_reset && !empty && status is not a fault code && (WINDOW_BYTES - occ + cons) >= status.
- Update:
  - occ_next = occ - cons + (accept_do ? status : 0).
  - New bytes land at positions occ-cons .. occ-cons+status-1.
  - Bytes from a popped entry are visible on fetch the cycle after accept_do; latency 1.
- Window full: no pop until enough bytes are consumed. The head entry remains presented and the FIFO is not read.
- Fault entry at head:
  - The entry is never popped, so later entries are never read.
  - fetch_limit / fetch_page_fault assert only when occ==0 and no pop is pending. While either flag is asserted, fetch_valid=0.
  - The flag holds until pr_reset or rst.
- pr_reset:
  - Next cycle occ=0.
  - accept_do=0 during the pr_reset cycle.
  - dec_consume is ignored in that cycle.
  - The FIFO is flushed by its owner, not by this block.
- Simultaneous events:
  - rst overrides pr_reset, which overrides consume and pop.
  - Consume and pop in the same cycle are legal and used for steady state.
- Arithmetic: occ and status are zero-extended to CNT_W+1 before the space compare, so there is no wrap.
- fetch data is a registered window. Zero-masking above fetch_valid is combinational.

Optional Feature:
- Macro: FETCH_ALIGN_BYPASS_EN.
- Defined, when occ==0, the FIFO is non-empty and the head entry is valid:
  - fetch shows the head entry bytes directly (combinational, zero latency) and fetch_valid = status.
  - The head is popped in the same cycle if dec_consume > 0 or the space rule holds.
  - Bytes status-cons are written into buf.
- Undefined: there is no bypass, and all bytes pass through buf with 1-cycle latency.

Test Plan:
- Reset, then release rst with the FIFO empty -> fetch_valid=0, accept_do=0, both fault flags 0, prefetch_eip tracks wr_eip=0x0000FFF0.
- Head entries status 8 then 5, dec_consume=0 ->
  - The 8-byte entry pops first; one cycle later occ=8.
  - The 5-byte entry then pops; occ=13.
  - The next status-8 entry stalls: accept_do=0 while occ=13.
- With occ=13, dec_consume=10 and a status-8 head -> pop in the same cycle; next cycle fetch_valid=11, fetch byte0 = old byte10, bytes 3..10 = new entry.
- occ=3, head status=PF_CODE ->
  - While bytes remain, flags stay 0 and accept_do stays 0.
  - After dec_consume=3: next cycle fetch_page_fault=1 and fetch_valid=0.
  - The flag holds until pr_reset, then clears on the next cycle.
- occ=9, dec_consume=4, pr_reset=1, head valid -> accept_do=0; next cycle fetch_valid=0, fetch=0.
- dec_consume=20 with occ=6 -> clamped; next cycle occ=0 and no underflow. With FETCH_ALIGN_BYPASS_EN: occ=0, head status 8, consume 3 -> fetch_valid=8 in the same cycle, next cycle fetch_valid=5.
